// File: rtl/ibex_pkg.sv
// Shared types for the register-file writeback path.
// Request fields are sized for the widest supported configuration; narrower builds zero-extend.
package ibex_pkg;

    localparam int RfAddrMaxW = 5;
    localparam int RfDataMaxW = 32;

    typedef struct packed {
        logic [RfAddrMaxW-1:0] addr;
        logic [RfDataMaxW-1:0] data;
    } rf_wr_req_t;

endpackage

// File: rtl/ibex_rf_bypass.sv
// Read-port bypass: returns the in-flight write data when it targets the register being read.
module ibex_rf_bypass #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5
) (
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    input  logic [DataWidth-1:0] rdata_raw_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic w_hit;

    assign w_hit   = we_i && (waddr_i == raddr_i);
    assign rdata_o = w_hit ? wdata_i : rdata_raw_i;

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Arbitrates the single register-file write port between EX (A) and LSU (B),
// registers the winning write and bypasses it onto both read ports.
module ibex_rf_wb_arbiter
    import ibex_pkg::*;
#(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 5,
    parameter int StarveLimit = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 a_valid_i,
    output logic                 a_ready_o,
    input  logic [AddrWidth-1:0] a_addr_i,
    input  logic [DataWidth-1:0] a_data_i,
    input  logic                 b_valid_i,
    output logic                 b_ready_o,
    input  logic [AddrWidth-1:0] b_addr_i,
    input  logic [DataWidth-1:0] b_data_i,
    output logic                 rf_we_o,
    output logic [AddrWidth-1:0] rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    input  logic [AddrWidth-1:0] raddr_a_i,
    input  logic [AddrWidth-1:0] raddr_b_i,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    input  logic [DataWidth-1:0] rf_rdata_b_i,
    output logic [DataWidth-1:0] rdata_a_o,
    output logic [DataWidth-1:0] rdata_b_o,
    output logic                 starve_o
);

    localparam int CntW = $clog2(StarveLimit + 1);

    logic [CntW-1:0] r_starve_cnt;
    logic            r_we;
    rf_wr_req_t      r_out;

    logic       w_a_pri;
    logic       w_grant_a;
    logic       w_grant_b;
    rf_wr_req_t w_req_a;
    rf_wr_req_t w_req_b;
    rf_wr_req_t w_win;

    always_comb begin
        w_req_a      = '0;
        w_req_a.addr = RfAddrMaxW'(a_addr_i);
        w_req_a.data = RfDataMaxW'(a_data_i);
        w_req_b      = '0;
        w_req_b.addr = RfAddrMaxW'(b_addr_i);
        w_req_b.data = RfDataMaxW'(b_data_i);
    end

    // B is preferred unless A has been passed over StarveLimit times in a row.
    assign w_a_pri   = (r_starve_cnt == CntW'(StarveLimit));
    assign w_grant_a = !rst_i && a_valid_i && (!b_valid_i || w_a_pri);
    assign w_grant_b = !rst_i && b_valid_i && !(a_valid_i && w_a_pri);
    assign w_win     = w_grant_a ? w_req_a : w_req_b;

    assign a_ready_o = w_grant_a;
    assign b_ready_o = w_grant_b;
    assign starve_o  = w_a_pri;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_starve_cnt <= '0;
        end else if (!a_valid_i || w_grant_a) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != CntW'(StarveLimit)) begin
            r_starve_cnt <= r_starve_cnt + CntW'(1);
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we  <= 1'b0;
            r_out <= '0;
        end else if (w_grant_a || w_grant_b) begin
            r_we  <= (w_win.addr != '0);
            r_out <= w_win;
        end else begin
            r_we  <= 1'b0;
        end
    end

    assign rf_we_o    = r_we;
    assign rf_waddr_o = r_out.addr[AddrWidth-1:0];
    assign rf_wdata_o = r_out.data[DataWidth-1:0];

    ibex_rf_bypass #(
        .DataWidth (DataWidth),
        .AddrWidth (AddrWidth)
    ) u_bypass_a (
        .we_i        (rf_we_o),
        .waddr_i     (rf_waddr_o),
        .wdata_i     (rf_wdata_o),
        .raddr_i     (raddr_a_i),
        .rdata_raw_i (rf_rdata_a_i),
        .rdata_o     (rdata_a_o)
    );

    ibex_rf_bypass #(
        .DataWidth (DataWidth),
        .AddrWidth (AddrWidth)
    ) u_bypass_b (
        .we_i        (rf_we_o),
        .waddr_i     (rf_waddr_o),
        .wdata_i     (rf_wdata_o),
        .raddr_i     (raddr_b_i),
        .rdata_raw_i (rf_rdata_b_i),
        .rdata_o     (rdata_b_o)
    );

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Directed, table-driven bench for ibex_rf_wb_arbiter (default parameters, StarveLimit=3).
module tb_ibex_rf_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        a_valid_i, b_valid_i;
    logic        a_ready_o, b_ready_o;
    logic [4:0]  a_addr_i, b_addr_i;
    logic [31:0] a_data_i, b_data_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [4:0]  raddr_a_i, raddr_b_i;
    logic [31:0] rf_rdata_a_i, rf_rdata_b_i;
    logic [31:0] rdata_a_o, rdata_b_o;
    logic        starve_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    ibex_rf_wb_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .a_valid_i    (a_valid_i),
        .a_ready_o    (a_ready_o),
        .a_addr_i     (a_addr_i),
        .a_data_i     (a_data_i),
        .b_valid_i    (b_valid_i),
        .b_ready_o    (b_ready_o),
        .b_addr_i     (b_addr_i),
        .b_data_i     (b_data_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .raddr_a_i    (raddr_a_i),
        .raddr_b_i    (raddr_b_i),
        .rf_rdata_a_i (rf_rdata_a_i),
        .rf_rdata_b_i (rf_rdata_b_i),
        .rdata_a_o    (rdata_a_o),
        .rdata_b_o    (rdata_b_o),
        .starve_o     (starve_o)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic [4:0]  ra;
        logic [31:0] rra;
        logic [4:0]  rb;
        logic [31:0] rrb;
        logic        e_ar;
        logic        e_br;
        logic        e_st;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_rda;
        logic [31:0] e_rdb;
    } vec_t;

    localparam int NV = 23;
    vec_t vec [NV];

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_i        = v.rst;
        a_valid_i    = v.av;
        a_addr_i     = v.aa;
        a_data_i     = v.ad;
        b_valid_i    = v.bv;
        b_addr_i     = v.ba;
        b_data_i     = v.bd;
        raddr_a_i    = v.ra;
        rf_rdata_a_i = v.rra;
        raddr_b_i    = v.rb;
        rf_rdata_b_i = v.rrb;
    endtask

    initial begin
        //                rst av aa  ad            bv ba  bd            ra  rra       rb  rrb      ar br st  we wa  wd            rda           rdb
        vec[0]  = '{1'b1,1'b1,5'd3,32'h11,       1'b1,5'd4,32'h22,       5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0,        32'h0,        32'h0};
        vec[1]  = '{1'b1,1'b1,5'd3,32'h11,       1'b1,5'd4,32'h22,       5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0,        32'h0,        32'h0};
        vec[2]  = '{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd5,32'hDEADBEEF, 5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b1,1'b0, 1'b0,5'd0,32'h0,        32'h0,        32'h0};
        vec[3]  = '{1'b0,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd5,32'h0,  5'd6,32'h55, 1'b0,1'b0,1'b0, 1'b1,5'd5,32'hDEADBEEF, 32'hDEADBEEF, 32'h55};
        vec[4]  = '{1'b0,1'b1,5'd1,32'hA1,       1'b1,5'd2,32'hB1,       5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b1,1'b0, 1'b0,5'd5,32'hDEADBEEF, 32'h0,        32'h0};
        vec[5]  = '{1'b0,1'b1,5'd1,32'hA1,       1'b1,5'd2,32'hB2,       5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b1,1'b0, 1'b1,5'd2,32'hB1,       32'h0,        32'h0};
        vec[6]  = '{1'b0,1'b1,5'd1,32'hA1,       1'b1,5'd2,32'hB3,       5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b1,1'b0, 1'b1,5'd2,32'hB2,       32'h0,        32'h0};
        vec[7]  = '{1'b0,1'b1,5'd1,32'hA1,       1'b1,5'd2,32'hB4,       5'd0,32'h0,  5'd0,32'h0,  1'b1,1'b0,1'b1, 1'b1,5'd2,32'hB3,       32'h0,        32'h0};
        vec[8]  = '{1'b0,1'b1,5'd1,32'hA2,       1'b1,5'd2,32'hB4,       5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b1,1'b0, 1'b1,5'd1,32'hA1,       32'h0,        32'h0};
        vec[9]  = '{1'b0,1'b1,5'd1,32'hA2,       1'b1,5'd2,32'hB5,       5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b1,1'b0, 1'b1,5'd2,32'hB4,       32'h0,        32'h0};
        vec[10] = '{1'b0,1'b1,5'd1,32'hA2,       1'b1,5'd2,32'hB6,       5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b1,1'b0, 1'b1,5'd2,32'hB5,       32'h0,        32'h0};
        vec[11] = '{1'b0,1'b1,5'd1,32'hA2,       1'b1,5'd2,32'hB7,       5'd0,32'h0,  5'd0,32'h0,  1'b1,1'b0,1'b1, 1'b1,5'd2,32'hB6,       32'h0,        32'h0};
        vec[12] = '{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd2,32'hB7,       5'd1,32'h99, 5'd2,32'h77, 1'b0,1'b1,1'b0, 1'b1,5'd1,32'hA2,       32'hA2,       32'h77};
        vec[13] = '{1'b0,1'b1,5'd0,32'h1234,     1'b0,5'd0,32'h0,        5'd0,32'h0,  5'd2,32'h0,  1'b1,1'b0,1'b0, 1'b1,5'd2,32'hB7,       32'h0,        32'hB7};
        vec[14] = '{1'b0,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b0,1'b0, 1'b0,5'd0,32'h1234,     32'h0,        32'h0};
        vec[15] = '{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd7,32'hCAFE,     5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b1,1'b0, 1'b0,5'd0,32'h1234,     32'h0,        32'h0};
        vec[16] = '{1'b0,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd7,32'h0,  5'd7,32'h5,  1'b0,1'b0,1'b0, 1'b1,5'd7,32'hCAFE,     32'hCAFE,     32'hCAFE};
        vec[17] = '{1'b0,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd7,32'h42, 5'd7,32'h5,  1'b0,1'b0,1'b0, 1'b0,5'd7,32'hCAFE,     32'h42,       32'h5};
        vec[18] = '{1'b0,1'b1,5'd9,32'h909,      1'b1,5'd10,32'hA0A,     5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b1,1'b0, 1'b0,5'd7,32'hCAFE,     32'h0,        32'h0};
        vec[19] = '{1'b0,1'b1,5'd9,32'h909,      1'b1,5'd11,32'hB0B,     5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b1,1'b0, 1'b1,5'd10,32'hA0A,     32'h0,        32'h0};
        vec[20] = '{1'b1,1'b1,5'd9,32'h909,      1'b1,5'd12,32'hC0C,     5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b0,1'b0, 1'b1,5'd11,32'hB0B,     32'h0,        32'h0};
        vec[21] = '{1'b0,1'b1,5'd9,32'h909,      1'b1,5'd12,32'hC0C,     5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b1,1'b0, 1'b0,5'd0,32'h0,        32'h0,        32'h0};
        vec[22] = '{1'b0,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd0,32'h0,  5'd0,32'h0,  1'b0,1'b0,1'b0, 1'b1,5'd12,32'hC0C,     32'h0,        32'h0};

        drive(vec[0]);
        @(posedge clk_i);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            drive(vec[i]);
            #1;
            chk("a_ready",  i, 32'(a_ready_o),  32'(vec[i].e_ar));
            chk("b_ready",  i, 32'(b_ready_o),  32'(vec[i].e_br));
            chk("starve",   i, 32'(starve_o),   32'(vec[i].e_st));
            chk("rf_we",    i, 32'(rf_we_o),    32'(vec[i].e_we));
            chk("rf_waddr", i, 32'(rf_waddr_o), 32'(vec[i].e_wa));
            chk("rf_wdata", i, rf_wdata_o,      vec[i].e_wd);
            chk("rdata_a",  i, rdata_a_o,       vec[i].e_rda);
            chk("rdata_b",  i, rdata_b_o,       vec[i].e_rdb);
        end

        // Sustained contention: expect B,B,B,A repeating; the winner lands on the write port next cycle.
        begin
            logic [7:0]  exp_a   = 8'b1000_1000;
            logic [4:0]  last_wa = 5'd0;
            logic [31:0] b_seq   = 32'h100;
            logic [31:0] a_seq   = 32'h200;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk_i);
                rst_i     = 1'b0;
                a_valid_i = 1'b1;
                a_addr_i  = 5'd20;
                a_data_i  = a_seq;
                b_valid_i = 1'b1;
                b_addr_i  = 5'd21;
                b_data_i  = b_seq;
                raddr_a_i = 5'd0;
                raddr_b_i = 5'd0;
                #1;
                if (k > 0) chk("seq_waddr", k, 32'(rf_waddr_o), 32'(last_wa));
                chk("seq_a_grant", k, 32'(a_ready_o), 32'(exp_a[k]));
                chk("seq_b_grant", k, 32'(b_ready_o), 32'(!exp_a[k]));
                chk("seq_starve",  k, 32'(starve_o),  32'(exp_a[k]));
                last_wa = exp_a[k] ? 5'd20 : 5'd21;
                if (exp_a[k]) a_seq = a_seq + 1;
                else          b_seq = b_seq + 1;
            end
            @(negedge clk_i);
            a_valid_i = 1'b0;
            b_valid_i = 1'b0;
            #1;
            chk("seq_last_we",    8, 32'(rf_we_o),    32'h1);
            chk("seq_last_waddr", 8, 32'(rf_waddr_o), 32'd20);
            chk("seq_last_wdata", 8, rf_wdata_o,      32'h201);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
